// File: rtl/psr_ctrl_pkg.sv
// Shared types for the pipeline stage register controller: phase encoding,
// bubble hold counter type and the default stage count used by psr instantiation.
package psr_ctrl_pkg;

   localparam int DEF_STAGES = 4;
   localparam int BUB_CNT_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   typedef logic [BUB_CNT_W-1:0] bub_cnt_t;

endpackage

// File: rtl/psr_bubble_slot.sv
// One stage's bubble tracker: mask bit, hold counter, insert/retire pulses.
// Pulses are registered (one cycle after the LOAD/SHIFT that caused them); no backpressure.
module psr_bubble_slot
   import psr_ctrl_pkg::*;
#(
   parameter int BUBBLE_CYC = 1
) (
   input  logic clk,
   input  logic clr,
   input  logic load_en,
   input  logic shift_en,
   input  logic hazard,
   output logic mask,
   output logic insert,
   output logic bubble,
   output logic bubble_clr
);

   bub_cnt_t cnt;

   // A hazard on an already-bubbled stage is ignored until the bubble retires.
   assign insert = load_en & hazard & ~mask;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         mask       <= 1'b0;
         cnt        <= '0;
         bubble     <= 1'b0;
         bubble_clr <= 1'b0;
      end else begin
         bubble     <= insert;
         bubble_clr <= 1'b0;
         if (insert) begin
            mask <= 1'b1;
            cnt  <= bub_cnt_t'(BUBBLE_CYC);
         end else if (shift_en && cnt != '0) begin
            cnt <= cnt - bub_cnt_t'(1);
            if (cnt == bub_cnt_t'(1)) begin
               bubble_clr <= 1'b1;
               mask       <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/psr_ctrl.sv
// Load-left/shift-right sequencer for a chain of psr stages; strobes are registered, one cycle
// after the phase state. stall freezes the phase. Optional counters under PSR_CTRL_PERF_EN.
module psr_ctrl
   import psr_ctrl_pkg::*;
#(
   parameter int STAGES     = DEF_STAGES,
   parameter int BUBBLE_CYC = 1,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              run,
   input  logic              stall,
   input  logic [STAGES-1:0] hazard,
   input  logic [STAGES-1:0] ri_req,
   output logic [STAGES-1:0] c_left,
   output logic [STAGES-1:0] c_right,
   output logic [STAGES-1:0] ld_ri,
   output logic [STAGES-1:0] bubble,
   output logic [STAGES-1:0] bubble_clr,
   output logic              busy,
   output logic [CNT_W-1:0]  cycle_cnt
`ifdef PSR_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0]  bubble_cnt,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   state_t state, state_nxt;
   state_t ret_phase, ret_nxt;
   logic   load_en, shift_en;
   logic [STAGES-1:0] mask, insert;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= IDLE;
         ret_phase <= LOAD;
      end else begin
         state     <= state_nxt;
         ret_phase <= ret_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ret_nxt   = ret_phase;
      case (state)
         IDLE: if (run && !stall) state_nxt = LOAD;
         LOAD: begin
            if (stall) begin
               state_nxt = HOLD;
               ret_nxt   = LOAD;
            end else begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (stall) begin
               state_nxt = HOLD;
               ret_nxt   = SHIFT;
            end else if (run) begin
               state_nxt = LOAD;
            end else begin
               state_nxt = IDLE;
            end
         end
         HOLD: if (!stall) state_nxt = ret_phase;
         default: state_nxt = IDLE;
      endcase
   end

   assign load_en  = (state == LOAD)  && !stall;
   assign shift_en = (state == SHIFT) && !stall;

   for (genvar k = 0; k < STAGES; k++) begin : g_slot
      psr_bubble_slot #(.BUBBLE_CYC(BUBBLE_CYC)) u_slot (
         .clk        (clk),
         .clr        (clr),
         .load_en    (load_en),
         .shift_en   (shift_en),
         .hazard     (hazard[k]),
         .mask       (mask[k]),
         .insert     (insert[k]),
         .bubble     (bubble[k]),
         .bubble_clr (bubble_clr[k])
      );
   end

   // Bubble beats ld_ri, ld_ri beats c_left; a bubbled stage gets neither load.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         c_left    <= '0;
         c_right   <= '0;
         ld_ri     <= '0;
         busy      <= 1'b0;
         cycle_cnt <= '0;
      end else begin
         c_left    <= load_en ? (~mask & ~insert & ~ri_req) : '0;
         ld_ri     <= load_en ? (~mask & ~insert & ri_req) : '0;
         c_right   <= shift_en ? '1 : '0;
         busy      <= (state_nxt != IDLE);
         if (shift_en) cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
   end

`ifdef PSR_CTRL_PERF_EN
   logic [CNT_W:0] bub_sum;

   always_comb begin
      bub_sum = {1'b0, bubble_cnt};
      for (int k = 0; k < STAGES; k++) bub_sum = bub_sum + (CNT_W+1)'(insert[k]);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         bubble_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         bubble_cnt <= bub_sum[CNT_W] ? '1 : bub_sum[CNT_W-1:0];
         if (state == HOLD && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_psr_ctrl.sv
// Directed bench for psr_ctrl (STAGES=4, BUBBLE_CYC=2, CNT_W=4).
module tb_psr_ctrl;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       run = 1'b0;
   logic       stall = 1'b0;
   logic [3:0] hazard = '0;
   logic [3:0] ri_req = '0;
   logic [3:0] c_left, c_right, ld_ri, bubble, bubble_clr;
   logic       busy;
   logic [3:0] cycle_cnt;
`ifdef PSR_CTRL_PERF_EN
   logic [3:0] bubble_cnt, stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   psr_ctrl #(.STAGES(4), .BUBBLE_CYC(2), .CNT_W(4)) dut (
      .clk        (clk),
      .clr        (clr),
      .run        (run),
      .stall      (stall),
      .hazard     (hazard),
      .ri_req     (ri_req),
      .c_left     (c_left),
      .c_right    (c_right),
      .ld_ri      (ld_ri),
      .bubble     (bubble),
      .bubble_clr (bubble_clr),
      .busy       (busy),
      .cycle_cnt  (cycle_cnt)
`ifdef PSR_CTRL_PERF_EN
      ,
      .bubble_cnt (bubble_cnt),
      .stall_cnt  (stall_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset, then release with run=1; returns with the FSM sitting in LOAD.
   task automatic start();
      clr = 1'b1; run = 1'b0; stall = 1'b0; hazard = '0; ri_req = '0;
      tick(); tick();
      clr = 1'b0; run = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      clr = 1'b1; run = 1'b1;
      tick(); tick();
      total++; if ({c_left, c_right, ld_ri, bubble, bubble_clr} !== 20'h0) begin
         bad++; $display("FAIL reset_strobes got=%h want=0", {c_left, c_right, ld_ri, bubble, bubble_clr}); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (cycle_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", cycle_cnt); end
      clr = 1'b0;
      tick();
      total++; if (busy !== 1'b1 || c_left !== 4'h0) begin
         bad++; $display("FAIL first_load busy=%b c_left=%h want 1/0", busy, c_left); end
      tick();
      total++; if (c_left !== 4'hF || c_right !== 4'h0) begin
         bad++; $display("FAIL load_strobe c_left=%h c_right=%h want F/0", c_left, c_right); end
      tick();
      total++; if (c_right !== 4'hF || c_left !== 4'h0 || cycle_cnt !== 4'd1) begin
         bad++; $display("FAIL shift_strobe c_right=%h c_left=%h cnt=%0d want F/0/1", c_right, c_left, cycle_cnt); end
      tick(); tick(); tick(); tick();
      total++; if (cycle_cnt !== 4'd3 || c_right !== 4'hF) begin
         bad++; $display("FAIL three_shifts cnt=%0d c_right=%h want 3/F", cycle_cnt, c_right); end
   endtask

   task automatic test_stall();
      start();
      tick(); tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (c_left !== 4'h0 || c_right !== 4'h0 || cycle_cnt !== 4'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL stall_load[%0d] c_left=%h c_right=%h cnt=%0d busy=%b want 0/0/1/1",
                            i, c_left, c_right, cycle_cnt, busy); end
      end
      stall = 1'b0;
      tick();
      total++; if (c_left !== 4'h0) begin bad++; $display("FAIL stall_return c_left=%h want 0", c_left); end
      tick();
      total++; if (c_left !== 4'hF || cycle_cnt !== 4'd1) begin
         bad++; $display("FAIL stall_resume c_left=%h cnt=%0d want F/1", c_left, cycle_cnt); end
      tick();
      tick();
      stall = 1'b1;
      tick();
      total++; if (c_right !== 4'h0 || cycle_cnt !== 4'd2) begin
         bad++; $display("FAIL stall_shift c_right=%h cnt=%0d want 0/2", c_right, cycle_cnt); end
      stall = 1'b0;
      tick();
      tick();
      total++; if (c_right !== 4'hF || cycle_cnt !== 4'd3) begin
         bad++; $display("FAIL shift_resume c_right=%h cnt=%0d want F/3", c_right, cycle_cnt); end
   endtask

   task automatic test_bubble();
      start();
      hazard = 4'b0100;
      tick();
      total++; if (bubble !== 4'b0100 || c_left !== 4'b1011) begin
         bad++; $display("FAIL bub_insert bubble=%b c_left=%b want 0100/1011", bubble, c_left); end
      hazard = 4'b0000;
      tick();
      total++; if (bubble !== 4'b0000 || bubble_clr !== 4'b0000 || c_right !== 4'hF) begin
         bad++; $display("FAIL bub_shift1 bubble=%b clr=%b c_right=%h want 0/0/F", bubble, bubble_clr, c_right); end
      tick();
      total++; if (c_left !== 4'b1011) begin bad++; $display("FAIL bub_masked_load c_left=%b want 1011", c_left); end
      tick();
      total++; if (bubble_clr !== 4'b0100 || c_right !== 4'hF) begin
         bad++; $display("FAIL bub_retire clr=%b c_right=%h want 0100/F", bubble_clr, c_right); end
      tick();
      total++; if (c_left !== 4'hF || bubble_clr !== 4'b0000) begin
         bad++; $display("FAIL bub_after c_left=%h clr=%b want F/0000", c_left, bubble_clr); end
   endtask

   task automatic test_ri_hazard();
      start();
      hazard = 4'b0001; ri_req = 4'b0011;
      tick();
      total++; if (bubble !== 4'b0001 || ld_ri !== 4'b0010 || c_left !== 4'b1100) begin
         bad++; $display("FAIL ri_bub bubble=%b ld_ri=%b c_left=%b want 0001/0010/1100", bubble, ld_ri, c_left); end
      ri_req = 4'b0000; hazard = 4'b1011;
      tick();
      tick();
      total++; if (bubble !== 4'b1010 || c_left !== 4'b0100 || ld_ri !== 4'b0000) begin
         bad++; $display("FAIL multi_bub bubble=%b c_left=%b ld_ri=%b want 1010/0100/0000", bubble, c_left, ld_ri); end
`ifdef PSR_CTRL_PERF_EN
      total++; if (bubble_cnt !== 4'd3) begin bad++; $display("FAIL perf_bub_cnt got=%0d want=3", bubble_cnt); end
`endif
      hazard = 4'b0000;
   endtask

   task automatic test_clr_pending();
      start();
      hazard = 4'b0100;
      tick();
      hazard = 4'b0000;
      tick(); tick();
      clr = 1'b1;
      tick();
      total++; if (bubble_clr !== 4'b0000 || busy !== 1'b0) begin
         bad++; $display("FAIL clr_mid clr=%b busy=%b want 0000/0", bubble_clr, busy); end
      clr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         total++; if (bubble_clr !== 4'b0000) begin
            bad++; $display("FAIL clr_no_retire[%0d] got=%b want=0000", i, bubble_clr); end
         if (i == 1) begin
            total++; if (c_left !== 4'hF) begin bad++; $display("FAIL clr_mask c_left=%h want F", c_left); end
         end
      end
   endtask

   task automatic test_wrap_idle();
      start();
      for (int i = 0; i < 32; i++) tick();
      total++; if (cycle_cnt !== 4'd0) begin bad++; $display("FAIL wrap16 got=%0d want=0", cycle_cnt); end
      tick(); tick();
      total++; if (cycle_cnt !== 4'd1) begin bad++; $display("FAIL wrap17 got=%0d want=1", cycle_cnt); end
      run = 1'b0;
      tick(); tick();
      total++; if (c_right !== 4'hF || busy !== 1'b0 || cycle_cnt !== 4'd2) begin
         bad++; $display("FAIL to_idle c_right=%h busy=%b cnt=%0d want F/0/2", c_right, busy, cycle_cnt); end
      tick(); tick();
      total++; if (c_left !== 4'h0 || c_right !== 4'h0 || cycle_cnt !== 4'd2) begin
         bad++; $display("FAIL idle_hold c_left=%h c_right=%h cnt=%0d want 0/0/2", c_left, c_right, cycle_cnt); end
   endtask

`ifdef PSR_CTRL_PERF_EN
   task automatic test_perf_stall();
      start();
      stall = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      total++; if (stall_cnt !== 4'hF) begin bad++; $display("FAIL perf_stall_sat got=%h want=F", stall_cnt); end
      stall = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_stall();
      test_bubble();
      test_ri_hazard();
      test_clr_pending();
      test_wrap_idle();
`ifdef PSR_CTRL_PERF_EN
      test_perf_stall();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/psr_ctrl.md
Name: psr_ctrl

Overview:
- Sequencer driving the control strobes of a chain of pipeline stage registers (psr instances): c_left, c_right, ld_ri, bubble, bubble_clr.
- Runs the two-phase load-left/shift-right cycle, freezes on stall, and injects and retires bubbles on hazard requests.
- Sits in the processor control path beside the decoder; one output bit per pipeline stage, bit 0 = psr between stages 0 and 1.

Parameters:
- STAGES, 4, number of psr instances controlled (2..8).
- BUBBLE_CYC, 1, number of SHIFT phases a bubble is held before bubble_clr is pulsed (1..7).
- CNT_W, 16, width of the cycle counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- clr  input  1  reset, asynchronous, active-high.
- run  input  1  1 = advance pipeline; 0 = go idle after the current phase completes.
- stall  input  1  1 = freeze the phase FSM; all strobes low that cycle.
- hazard  input  STAGES  per-stage bubble request, sampled only in LOAD.
- ri_req  input  STAGES  per-stage register-index reload request, sampled only in LOAD.
- c_left  output  STAGES  load-left strobe per stage.
- c_right  output  STAGES  shift-right strobe per stage.
- ld_ri  output  STAGES  Ri-only load strobe per stage.
- bubble  output  STAGES  bubble insert pulse per stage.
- bubble_clr  output  STAGES  bubble retire pulse per stage.
- busy  output  1  1 when FSM is not IDLE.
- cycle_cnt  output  CNT_W  count of completed SHIFT phases, wraps at 2^CNT_W.

Behaviour:
- All outputs are registered. clr forces: state = IDLE, all strobe vectors = 0, busy = 0, cycle_cnt = 0, all bubble counters = 0, active-bubble mask = 0. Reset mid-operation abandons any pending bubble_clr.
- FSM states: IDLE, LOAD, SHIFT, HOLD.
  - IDLE -> LOAD when run = 1 and stall = 0.
  - LOAD -> SHIFT next cycle unless stall = 1.
  - SHIFT -> LOAD when run = 1, otherwise -> IDLE; both only when stall = 0.
  - LOAD or SHIFT -> HOLD when stall = 1. The FSM stores the return phase.
  - HOLD -> stored phase on the first cycle with stall = 0. Strobes resume the cycle after the return.
- Strobe timing: strobes assert the cycle after the state is entered and last exactly one clk.
  - LOAD: c_left[k] = 1 for every stage k not in the active-bubble mask.
  - LOAD with ri_req[k] = 1: ld_ri[k] = 1 and c_left[k] = 0. ld_ri has priority over c_left.
  - SHIFT: c_right = all ones.
- Bubble insert: in LOAD, hazard[k] = 1 with mask[k] = 0 causes:
  - bubble[k] = 1 for one cycle;
  - c_left[k] = 0 and ld_ri[k] = 0;
  - mask[k] = 1 and counter[k] = BUBBLE_CYC.
- hazard[k] while mask[k] = 1 is ignored; no second pulse.
- Bubble retire: each SHIFT decrements every nonzero counter. The SHIFT that takes counter[k] to 0 also drives bubble_clr[k] = 1 alongside c_right[k] and clears mask[k]. The psr drops its bubble flag on that edge in preference to shifting.
- Simultaneous requests: hazards on several stages are handled independently in the same LOAD. hazard[k] and ri_req[k] together: the bubble wins and ld_ri[k] = 0.
- HOLD and IDLE: every strobe is 0, counters are frozen, and cycle_cnt is held.
- cycle_cnt increments on each SHIFT strobe cycle and wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro PSR_CTRL_PERF_EN.
  - When defined, adds outputs bubble_cnt [CNT_W-1:0] and stall_cnt [CNT_W-1:0]. bubble_cnt counts bubble pulses (popcount per cycle). stall_cnt counts HOLD cycles. Both reset to 0 on clr and saturate at all ones.
  - When undefined, these ports and counters are absent and all other behaviour is identical.

Decomposition:
- Shared package psr_ctrl_pkg holds:
  - the state encoding: IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, HOLD = 2'd3;
  - a 3-bit bubble-counter type;
  - the default STAGES constant, shared with psr instantiation.
- One sub-module, psr_bubble_slot, holds one stage's mask bit, counter and bubble/bubble_clr pulse logic. It is instantiated STAGES times through generate.

Test Plan:
- clr = 1 while run = 1 -> all outputs 0 and busy = 0. Release clr with run = 1 -> c_left = 4'hF and c_right = 4'hF on alternating cycles; cycle_cnt = 3 after 3 SHIFTs.
- stall = 1 for 3 cycles during LOAD -> strobes 0 for those cycles; the FSM resumes at LOAD and c_left = 4'hF the cycle after the return; cycle_cnt unchanged while stalled.
- hazard = 4'b0100 in LOAD, BUBBLE_CYC = 2 -> bubble = 4'b0100 and c_left = 4'b1011. The next LOAD has c_left = 4'b1011. The 2nd SHIFT has bubble_clr = 4'b0100. The following LOAD has c_left = 4'hF.
- ri_req = 4'b0001 and hazard = 4'b0001 in the same LOAD -> bubble = 4'b0001, ld_ri = 0, c_left = 4'b1110. A repeat hazard[0] while masked -> no bubble pulse.
- clr pulsed one cycle before a pending bubble_clr -> no bubble_clr is ever emitted; mask = 0 after reset.
- CNT_W = 4, 17 SHIFTs -> cycle_cnt = 1. With PSR_CTRL_PERF_EN, 20 stall cycles -> stall_cnt = 4'hF (saturated).
